// File: rtl/ped_xing_pkg.sv
// Shared types for the pedestrian crossing controller: phase enum, lamp indices
// and the fixed phase ordering.
package ped_xing_pkg;

    typedef enum logic [2:0] {
        TGREEN     = 3'd0,
        TYELLOW    = 3'd1,
        ALLRED_IN  = 3'd2,
        PWALK      = 3'd3,
        PCLEAR     = 3'd4,
        ALLRED_OUT = 3'd5
    } xing_state_t;

    localparam int LAMP_R   = 0;
    localparam int LAMP_Y   = 1;
    localparam int LAMP_G   = 2;
    localparam int LAMP_NUM = 3;

    // Phases only ever advance in this fixed ring.
    function automatic xing_state_t next_phase(input xing_state_t s);
        case (s)
            TGREEN:     return TYELLOW;
            TYELLOW:    return ALLRED_IN;
            ALLRED_IN:  return PWALK;
            PWALK:      return PCLEAR;
            PCLEAR:     return ALLRED_OUT;
            default:    return TGREEN;
        endcase
    endfunction

endpackage

// File: rtl/ped_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, with synchronous clear,
// optional saturation at limit-1 and a done flag when count == limit-1.
module ped_phase_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sat,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] last;

    assign last = limit - CNT_W'(1);
    assign done = (count == last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!(sat && done)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ped_xing_ctrl.sv
// Traffic/pedestrian intersection controller for N_XING crossings on one approach.
// Optional walk+clear countdown output enabled by defining PED_COUNTDOWN_EN.
module ped_xing_ctrl
    import ped_xing_pkg::*;
#(
    parameter int N_XING      = 2,
    parameter int CNT_W       = 25,
    parameter int T_MIN_GREEN = 2**24,
    parameter int T_YELLOW    = 2**23,
    parameter int T_ALLRED    = 2**22,
    parameter int T_WALK      = 2**24,
    parameter int T_FLASH     = 2**23,
    parameter int FLASH_BIT   = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_XING-1:0] ped_req,
    output logic              t_r,
    output logic              t_y,
    output logic              t_g,
    output logic [N_XING-1:0] p_walk,
    output logic [N_XING-1:0] p_dontwalk
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [CNT_W-1:0]  p_count
`endif
);

    localparam logic [CNT_W-1:0] LIM_GREEN  = CNT_W'(T_MIN_GREEN);
    localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(T_ALLRED);
    localparam logic [CNT_W-1:0] LIM_WALK   = CNT_W'(T_WALK);
    localparam logic [CNT_W-1:0] LIM_FLASH  = CNT_W'(T_FLASH);

    xing_state_t          state, state_nxt;
    logic [N_XING-1:0]    pending, pending_nxt;
    logic [N_XING-1:0]    serve, serve_nxt;
    logic [CNT_W-1:0]     timer, limit;
    logic                 timer_done, timer_sat, phase_exit;
    logic [LAMP_NUM-1:0]  lamps;

    ped_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (phase_exit),
        .sat   (timer_sat),
        .limit (limit),
        .count (timer),
        .done  (timer_done)
    );

    always_comb begin
        limit = LIM_ALLRED;
        case (state)
            TGREEN:  limit = LIM_GREEN;
            TYELLOW: limit = LIM_YELLOW;
            PWALK:   limit = LIM_WALK;
            PCLEAR:  limit = LIM_FLASH;
            default: limit = LIM_ALLRED;
        endcase
    end

    // Green holds at min-green until something is pending; other phases run fixed lengths.
    always_comb begin
        timer_sat  = (state == TGREEN) && !(|pending);
        phase_exit = timer_done && ((state != TGREEN) || (|pending));
        state_nxt  = phase_exit ? next_phase(state) : state;
    end

    always_comb begin
        pending_nxt = pending | ped_req;
        serve_nxt   = serve;
        case (state)
            ALLRED_IN: begin
                if (phase_exit) begin
                    serve_nxt   = pending | ped_req;
                    pending_nxt = '0;
                end
            end
            PWALK: begin
                // A crossing already walking absorbs its own button presses.
                pending_nxt = pending | (ped_req & ~serve);
            end
            ALLRED_OUT: begin
                if (phase_exit) begin
                    serve_nxt = '0;
                end
            end
            default: begin
                pending_nxt = pending | ped_req;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TGREEN;
            pending <= '0;
            serve   <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            serve   <= serve_nxt;
        end
    end

    always_comb begin
        lamps         = '0;
        lamps[LAMP_G] = (state == TGREEN);
        lamps[LAMP_Y] = (state == TYELLOW);
        lamps[LAMP_R] = (state != TGREEN) && (state != TYELLOW);
        t_r = lamps[LAMP_R];
        t_y = lamps[LAMP_Y];
        t_g = lamps[LAMP_G];
    end

    always_comb begin
        p_walk     = (state == PWALK) ? serve : '0;
        p_dontwalk = ~p_walk;
        for (int i = 0; i < N_XING; i++) begin
            if ((state == PCLEAR) && serve[i]) begin
                p_dontwalk[i] = ~timer[FLASH_BIT];
            end
        end
    end

`ifdef PED_COUNTDOWN_EN
    localparam logic [CNT_W-1:0] CNT_WALK_TOP  = CNT_W'(T_WALK + T_FLASH - 1);
    localparam logic [CNT_W-1:0] CNT_FLASH_TOP = CNT_W'(T_FLASH - 1);

    always_comb begin
        p_count = '0;
        case (state)
            PWALK:   p_count = CNT_WALK_TOP - timer;
            PCLEAR:  p_count = CNT_FLASH_TOP - timer;
            default: p_count = '0;
        endcase
    end
`else
    logic unused_timer_bits;
    assign unused_timer_bits = ^timer;
`endif

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Self-checking bench for ped_xing_ctrl: table vectors, corner sequences and
// randomized requests against a phase-schedule reference model.
module tb_ped_xing_ctrl;

    localparam int N   = 2;
    localparam int CW  = 8;
    localparam int TMG = 8;
    localparam int TY  = 3;
    localparam int TAR = 2;
    localparam int TW  = 5;
    localparam int TF  = 4;
    localparam int FB  = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] ped_req;
    logic         t_r, t_y, t_g;
    logic [N-1:0] p_walk, p_dontwalk;
`ifdef PED_COUNTDOWN_EN
    logic [CW-1:0] p_count;
`endif

    ped_xing_ctrl #(
        .N_XING      (N),
        .CNT_W       (CW),
        .T_MIN_GREEN (TMG),
        .T_YELLOW    (TY),
        .T_ALLRED    (TAR),
        .T_WALK      (TW),
        .T_FLASH     (TF),
        .FLASH_BIT   (FB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ped_req    (ped_req),
        .t_r        (t_r),
        .t_y        (t_y),
        .t_g        (t_g),
        .p_walk     (p_walk),
        .p_dontwalk (p_dontwalk)
`ifdef PED_COUNTDOWN_EN
        ,
        .p_count    (p_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase index in the ring (0=green .. 5=all-red out),
    // cycles elapsed in the phase, pending and served crossings.
    int           m_phase;
    int           m_el;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_serve;

    function automatic int phase_len(input int p);
        case (p)
            0:       return TMG;
            1:       return TY;
            3:       return TW;
            4:       return TF;
            default: return TAR;
        endcase
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_el    = 0;
        m_pend  = '0;
        m_serve = '0;
    endfunction

    function automatic void model_step(input logic [N-1:0] req);
        bit leave;
        if (m_phase == 0) leave = (m_el >= TMG - 1) && (m_pend != 0);
        else              leave = (m_el == phase_len(m_phase) - 1);
        if (m_phase == 2 && leave) begin
            m_serve = m_pend | req;
            m_pend  = '0;
        end else if (m_phase == 3) begin
            m_pend = m_pend | (req & ~m_serve);
        end else begin
            m_pend = m_pend | req;
        end
        if (leave) begin
            if (m_phase == 5) m_serve = '0;
            m_phase = (m_phase + 1) % 6;
            m_el    = 0;
        end else if (!(m_phase == 0 && m_el >= TMG - 1)) begin
            m_el = m_el + 1;
        end
    endfunction

    // Packed as {t_r, t_y, t_g, walk[1:0], dontwalk[1:0]}.
    function automatic logic [6:0] model_out();
        logic [N-1:0] w, dw;
        logic tr, ty, tg;
        tg = (m_phase == 0);
        ty = (m_phase == 1);
        tr = !tg && !ty;
        w  = (m_phase == 3) ? m_serve : '0;
        for (int i = 0; i < N; i++) begin
            if (m_phase == 4 && m_serve[i]) dw[i] = (((m_el >> FB) & 1) == 0);
            else                            dw[i] = !w[i];
        end
        return {tr, ty, tg, w, dw};
    endfunction

    function automatic logic [6:0] dut_out();
        return {t_r, t_y, t_g, p_walk, p_dontwalk};
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int exp_cnt;
        cmp({tag, "_model"}, 32'(dut_out()), 32'(model_out()));
        cmp({tag, "_lamp_safety"},
            32'(((32'(t_r) + 32'(t_y) + 32'(t_g)) == 1) && (p_walk == '0 || t_r)), 32'd1);
`ifdef PED_COUNTDOWN_EN
        if (m_phase == 3)      exp_cnt = TW + TF - 1 - m_el;
        else if (m_phase == 4) exp_cnt = TF - 1 - m_el;
        else                   exp_cnt = 0;
        cmp({tag, "_count"}, 32'(p_count), 32'(exp_cnt));
`else
        exp_cnt = 0;
`endif
    endtask

    task automatic tick(input logic [N-1:0] req, input string tag,
                        input bit use_exp, input logic [6:0] exp);
        ped_req = req;
        @(negedge clk);
        if (use_exp) cmp({tag, "_expect"}, 32'(dut_out()), 32'(exp));
        check_model(tag);
        @(posedge clk);
        model_step(req);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        ped_req = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cmp("reset_state", 32'(dut_out()), 32'(7'b0010011));
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           n;
        logic [6:0]   exp;
    } vec_t;

    vec_t tbl[10];
    logic [N-1:0] rq;

    initial begin
        tbl[0] = '{2'b00, 20, 7'b0010011};
        tbl[1] = '{2'b01,  1, 7'b0010011};
        tbl[2] = '{2'b00,  1, 7'b0010011};
        tbl[3] = '{2'b00,  3, 7'b0100011};
        tbl[4] = '{2'b00,  2, 7'b1000011};
        tbl[5] = '{2'b00,  5, 7'b1000110};
        tbl[6] = '{2'b00,  2, 7'b1000011};
        tbl[7] = '{2'b00,  2, 7'b1000010};
        tbl[8] = '{2'b00,  2, 7'b1000011};
        tbl[9] = '{2'b00, 30, 7'b0010011};

        // Single pulse on crossing 0 after min green, full walk cycle.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                tick(tbl[r].req, "table", 1'b1, tbl[r].exp);
            end
        end

        // Request before min green is met: yellow exactly at cycle 8.
        do_reset();
        for (int j = 0; j < 14; j++) begin
            rq = (j == 2) ? 2'b10 : 2'b00;
            if (j == 7)       tick(rq, "early_green", 1'b1, 7'b0010011);
            else if (j == 8)  tick(rq, "early_yellow", 1'b1, 7'b0100011);
            else if (j == 13) tick(rq, "early_walk", 1'b1, 7'b1001001);
            else              tick(rq, "early", 1'b0, 7'b0);
        end

        // Held own request is absorbed; other crossing's request waits for next walk.
        do_reset();
        for (int j = 0; j < 42; j++) begin
            if (j == 0)                 rq = 2'b01;
            else if (j == 14)           rq = 2'b11;
            else if (j >= 13 && j <= 17) rq = 2'b01;
            else                        rq = 2'b00;
            if (j == 13)      tick(rq, "absorb_walk0", 1'b1, 7'b1000110);
            else if (j == 24) tick(rq, "absorb_green", 1'b1, 7'b0010011);
            else if (j == 37) tick(rq, "absorb_walk1", 1'b1, 7'b1001001);
            else              tick(rq, "absorb", 1'b0, 7'b0);
        end

        // Asynchronous reset on the third walk cycle.
        do_reset();
        for (int j = 0; j < 15; j++) begin
            tick((j == 0) ? 2'b01 : 2'b00, "pre_rst", 1'b0, 7'b0);
        end
        cmp("walk_before_reset", 32'(dut_out()), 32'(7'b1000110));
        reset = 1'b1;
        #1;
        cmp("reset_mid_walk", 32'(dut_out()), 32'(7'b0010011));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick(2'b00, "post_rst", (j == 11), 7'b0010011);
        end

        // Continuous requests on both crossings.
        for (int j = 0; j < 120; j++) tick(2'b11, "continuous", 1'b0, 7'b0);

        // Randomized sparse and bursty requests.
        do_reset();
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 9) == 0) rq = 2'($urandom_range(0, 3));
            else                           rq = 2'b00;
            tick(rq, "random", 1'b0, 7'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
